// File: rtl/reaction_game_ctrl_if.sv
// Result hand-off channel between the reaction game controller and the SPI driver.
// Master offers tx_data with tx_valid; slave accepts with tx_ready.
interface reaction_game_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game sequencer: random wait, LED stimulus, tick timing, result hand-off.
// Optional best-time tracking is enabled by defining REACTION_BEST_EN.
//
// state    | meaning
// IDLE     | waiting for start
// ARMED    | random wait running, LED off, a press is a false start
// TIMING   | LED on, counting ticks until press or 255-tick timeout
// REPORT   | result offered on tx channel until accepted
module reaction_game_ctrl #(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned MIN_WAIT = 50
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 button,
    output logic                 led_on,
    output logic [7:0]           time_out,
    output logic                 false_start,
    output logic                 busy,
    output logic [7:0]           best_time,
    reaction_game_ctrl_if.master tx
);

    localparam logic [15:0] PRESC_LOAD = 16'(TICK_DIV - 1);
    localparam logic [8:0]  MIN_WAIT_W = 9'(MIN_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_TIMING,
        S_REPORT
    } state_t;

    state_t      state_q;
    logic [7:0]  lfsr_q;
    logic [7:0]  lfsr_d;
    logic [15:0] presc_q;
    logic [8:0]  wait_q;
    logic [7:0]  count_q;
    logic        button_q;
    logic        led_on_q;
    logic        busy_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic [7:0]  time_out_q;
    logic        false_start_q;

    logic        press;
    logic        tick;
    logic        report_go;
    logic [7:0]  result_d;
    logic        false_d;

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign press  = button & ~button_q;
    assign tick   = (presc_q == 16'd0);

    // A press wins over the final tick, so a late press still reports FE rather than timeout.
    always_comb begin
        report_go = 1'b0;
        result_d  = count_q;
        false_d   = 1'b0;
        case (state_q)
            S_ARMED: begin
                if (press) begin
                    report_go = 1'b1;
                    result_d  = 8'h00;
                    false_d   = 1'b1;
                end
            end
            S_TIMING: begin
                if (press) begin
                    report_go = 1'b1;
                    result_d  = (count_q == 8'hFF) ? 8'hFE : count_q;
                end else if (tick && count_q == 8'hFE) begin
                    report_go = 1'b1;
                    result_d  = 8'hFF;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            lfsr_q        <= 8'hA5;
            presc_q       <= PRESC_LOAD;
            wait_q        <= 9'd0;
            count_q       <= 8'd0;
            button_q      <= 1'b0;
            led_on_q      <= 1'b0;
            busy_q        <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            time_out_q    <= 8'h00;
            false_start_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            button_q <= button;
            presc_q  <= tick ? PRESC_LOAD : presc_q - 16'd1;

            if (report_go) begin
                state_q       <= S_REPORT;
                led_on_q      <= 1'b0;
                tx_valid_q    <= 1'b1;
                tx_data_q     <= result_d;
                time_out_q    <= result_d;
                false_start_q <= false_d;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q <= S_ARMED;
                            busy_q  <= 1'b1;
                            wait_q  <= MIN_WAIT_W + {2'b00, lfsr_q[6:0]};
                            presc_q <= PRESC_LOAD;
                        end
                    end
                    S_ARMED: begin
                        if (wait_q == 9'd0) begin
                            state_q  <= S_TIMING;
                            led_on_q <= 1'b1;
                            count_q  <= 8'd0;
                            presc_q  <= PRESC_LOAD;
                        end else if (tick) begin
                            wait_q <= wait_q - 9'd1;
                        end
                    end
                    S_TIMING: begin
                        if (tick) begin
                            count_q <= count_q + 8'd1;
                        end
                    end
                    S_REPORT: begin
                        if (tx.tx_ready) begin
                            state_q    <= S_IDLE;
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef REACTION_BEST_EN
    logic [7:0] best_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_q <= 8'hFF;
        end else if (report_go && !false_d && result_d != 8'hFF && result_d < best_q) begin
            best_q <= result_d;
        end
    end

    assign best_time = best_q;
`else
    assign best_time = 8'hFF;
`endif

    assign led_on      = led_on_q;
    assign busy        = busy_q;
    assign time_out    = time_out_q;
    assign false_start = false_start_q;
    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl with TICK_DIV=4, MIN_WAIT=2: directed and random rounds
// checked against a tick-arithmetic model of wait length, reaction result and best time.
module tb_reaction_game_ctrl;

    localparam int TICK_DIV = 4;
    localparam int MIN_WAIT = 2;
    localparam int TIMEOUT_CYC = 255 * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       button = 1'b0;
    logic       led_on;
    logic       false_start;
    logic       busy;
    logic [7:0] time_out;
    logic [7:0] best_time;

    reaction_game_ctrl_if tx ();

    int checks = 0;
    int failures = 0;
    int exp_best = 255;
    logic [7:0] m_lfsr;

    always #5 clk = ~clk;

    reaction_game_ctrl #(.TICK_DIV(TICK_DIV), .MIN_WAIT(MIN_WAIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .button     (button),
        .led_on     (led_on),
        .time_out   (time_out),
        .false_start(false_start),
        .busy       (busy),
        .best_time  (best_time),
        .tx         (tx)
    );

    // Reference random source: polynomial x^8+x^6+x^5+x^4+1, seeded A5 by reset.
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_best_out();
`ifdef REACTION_BEST_EN
        return exp_best;
`else
        return 255;
`endif
    endfunction

    // mode 0: press d cycles after LED seen; 1: press during wait; 2: no press; 3: button held from before start
    task automatic run_round(input int mode, input int d, input int hold);
        int w, k, led_k, r, exp_res, exp_r;
        int fs;
        led_k = -1;
        r = -1;
        if (mode == 3) begin
            button = 1'b1;
            repeat (2) @(negedge clk);
        end
        w = MIN_WAIT + int'(m_lfsr[6:0]);
        if (mode == 1) d = 1 + (d % (TICK_DIV * w));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (r < 0 && k < 3000) begin
            if (tx.tx_valid) begin
                r = k;
            end else begin
                if (led_on && led_k < 0) led_k = k;
                if (mode == 0 && led_k >= 0 && k == led_k + d) button = 1'b1;
                if (mode == 1 && k == d) button = 1'b1;
                @(negedge clk);
                k++;
            end
        end
        chk("report_seen", 32'(r >= 0), 32'd1);

        case (mode)
            0: begin
                exp_res = (d / TICK_DIV > 254) ? 254 : d / TICK_DIV;
                exp_r   = led_k + d + 1;
                fs      = 0;
            end
            1: begin
                exp_res = 0;
                exp_r   = d + 1;
                fs      = 1;
            end
            default: begin
                exp_res = 255;
                exp_r   = led_k + TIMEOUT_CYC;
                fs      = 0;
            end
        endcase

        if (mode == 1) chk("led_never_on", 32'(led_k), 32'hFFFF_FFFF);
        else           chk("led_latency", 32'(led_k), 32'(TICK_DIV * w + 2));
        chk("report_cycle", 32'(r), 32'(exp_r));
        chk("tx_data", 32'(tx.tx_data), 32'(exp_res));
        chk("false_start", 32'(false_start), 32'(fs));
        chk("time_out", 32'(time_out), 32'(exp_res));
        chk("led_off_report", 32'(led_on), 32'd0);

        if (fs == 0 && exp_res != 255 && exp_res < exp_best) exp_best = exp_res;
        chk("best_time", 32'(best_time), 32'(exp_best_out()));

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(tx.tx_valid), 32'd1);
            chk("hold_data", 32'(tx.tx_data), 32'(exp_res));
        end
        tx.tx_ready = 1'b1;
        @(negedge clk);
        tx.tx_ready = 1'b0;
        button = 1'b0;
        chk("valid_dropped", 32'(tx.tx_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("time_out_kept", 32'(time_out), 32'(exp_res));
        @(negedge clk);
    endtask

    initial begin
        int k, seen_valid;
        tx.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led_on), 32'd0);
        chk("rst_valid", 32'(tx.tx_valid), 32'd0);
        chk("rst_data", 32'(tx.tx_data), 32'd0);
        chk("rst_time_out", 32'(time_out), 32'd0);
        chk("rst_false_start", 32'(false_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_best", 32'(best_time), 32'hFF);
        rst_n = 1'b1;
        @(negedge clk);

        run_round(0, 20, 3);
        run_round(0, 36, 1);
        run_round(0, 16, 0);
        run_round(2, 0, 2);
        run_round(1, 7, 1);
        run_round(3, 0, 0);
        run_round(0, 1019, 0);
        run_round(0, 3, 0);
        run_round(0, 4, 1);
        for (int i = 0; i < 6; i++) begin
            run_round(int'($urandom_range(1, 0)), int'($urandom_range(900, 0)),
                      int'($urandom_range(3, 0)));
        end

        // Reset in the middle of the LED phase
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!led_on && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("mid_led_seen", 32'(led_on), 32'd1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        exp_best = 255;
        chk("mid_rst_led", 32'(led_on), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(tx.tx_valid), 32'd0);
        chk("mid_rst_time_out", 32'(time_out), 32'd0);
        chk("mid_rst_best", 32'(best_time), 32'hFF);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx.tx_valid) seen_valid++;
        end
        chk("no_valid_after_rst", 32'(seen_valid), 32'd0);
        chk("idle_after_rst", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reaction_game_ctrl.md
REACTION_GAME_CTRL -- requirements
Module: reaction_game_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: clk cycles per timing tick (range 2..65535).
REQ-002 SHALL have parameter MIN_WAIT, default 50: minimum random-wait length in ticks (8-bit).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  request to begin a round; sampled in IDLE only.
REQ-006 SHALL have port button  input  1  player button, already synchronised, active-high.
REQ-007 SHALL have port led_on  output  1  stimulus LED, high while the player must react.
REQ-008 SHALL have port tx_data  output  8  round result offered to the SPI driver.
REQ-009 SHALL have port tx_valid  output  1  tx_data is valid.
REQ-010 SHALL have port tx_ready  input  1  SPI driver accepts tx_data.
REQ-011 SHALL have port time_out  output  8  result of the last completed round.
REQ-012 SHALL have port false_start  output  1  last round ended by an early press.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port best_time  output  8  best valid result (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, ARMED, TIMING and REPORT.
REQ-016 SHALL move IDLE->ARMED when start=1; start is ignored in all other states.
REQ-017 SHALL run an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, stepping every cycle.
REQ-018 SHALL, on the IDLE->ARMED transition, load wait = MIN_WAIT + lfsr[6:0] ticks (9-bit sum, no wrap).
REQ-019 SHALL restart the tick prescaler at 0 on every entry to ARMED and to TIMING.
REQ-020 SHALL emit one tick every TICK_DIV cycles while in ARMED or TIMING.
REQ-021 SHALL in ARMED decrement wait per tick and enter TIMING on the cycle after wait reaches 0.
REQ-022 SHALL detect a press as a button rising edge (previous sample 0, current sample 1); a held button is never a press.
REQ-023 SHALL on a press in ARMED set result=8'h00, go to REPORT next cycle and set false_start=1.
REQ-024 SHALL keep led_on=1 exactly while in TIMING and increment an 8-bit count per tick, count starting at 0.
REQ-025 SHALL on a press in TIMING go to REPORT next cycle with result=count, clamped to at most 8'hFE; false_start=0.
REQ-026 SHALL on count reaching 255 in TIMING with no press go to REPORT with result=8'hFF (timeout); false_start=0.
REQ-027 SHALL, when a press and the count-255 tick occur in the same cycle, resolve as a press with result 8'hFE.
REQ-028 SHALL update time_out on REPORT entry; led_on=0 and tx_valid=1 from the first REPORT cycle.
REQ-029 SHALL hold tx_data=result stable while tx_valid=1 and tx_ready=0.
REQ-030 SHALL on tx_valid&&tx_ready drop tx_valid and return to IDLE on the next cycle.
REQ-031 SHALL never raise tx_valid outside REPORT.

Reset
REQ-032 SHALL, while rst_n=0 at a clk edge, enter IDLE with led_on=0, tx_valid=0, tx_data=0, time_out=0, false_start=0, busy=0, best_time=8'hFF and lfsr=8'hA5.
REQ-033 SHALL abort any round on reset mid-operation; no tx_valid pulse follows reset.

Configuration
REQ-034 SHALL, when REACTION_BEST_EN is defined, set best_time to min(best_time, result) on REPORT entry for a valid result (not false start, not 8'hFF).
REQ-035 SHALL, when REACTION_BEST_EN is undefined, tie best_time to constant 8'hFF with no tracking register.

Verification
REQ-036 Bench SHALL use TICK_DIV=4 and MIN_WAIT=2 and cover these scenarios:
REQ-037 Reset, then start pulse -> busy=1; led_on rises after (2+lfsr[6:0])*4 cycles, +1 cycle per REQ-021.
REQ-038 Press 5 ticks after led_on -> tx_data=8'h05, tx_valid=1, false_start=0; tx_ready high 3 cycles later -> IDLE next cycle with time_out=8'h05.
REQ-039 Press during ARMED -> led_on never rises; tx_data=8'h00, false_start=1.
REQ-040 No press in TIMING -> tx_data=8'hFF after 255 ticks; button held high from start -> also 8'hFF.
REQ-041 Rounds with results 9, 4, FF and false start, REACTION_BEST_EN defined -> best_time=8'h04; undefined -> 8'hFF.
REQ-042 rst_n low mid-TIMING -> next cycle led_on=0, IDLE state, and no tx_valid afterwards.
